// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register file write-port arbiter: pipeline priority, 2-entry aux FIFO, starvation force
module rf_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we,
    input  logic [ADDR_W-1:0]        pipe_waddr,
    input  logic [DATA_W-1:0]        pipe_wdata,
    output logic                     stall_req,
    input  logic                     aux_valid,
    input  logic [ADDR_W-1:0]        aux_waddr,
    input  logic [DATA_W-1:0]        aux_wdata,
    output logic                     aux_ready,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [(2**ADDR_W)-1:0]   aux_pend_mask
);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t              state_q;
    logic [3:0]          starve_cnt_q;

    logic [ADDR_W-1:0]   ent_addr_q [2];
    logic [DATA_W-1:0]   ent_data_q [2];
    logic                rd_ptr_q;
    logic                wr_ptr_q;
    logic [1:0]          count_q;
    logic [1:0]          count_d;

    logic                head_valid;
    logic                in_force;
    logic                push;
    logic                pop;

    // Grant decision: a forced cycle always drains the head; otherwise the head only
    // takes slots the pipeline leaves idle. r0 pushes are acknowledged but never stored.
    always_comb begin
        head_valid = (count_q != 2'd0);
        in_force   = (state_q == ST_FORCE);
        aux_ready  = !rst && (count_q != 2'd2);
        push       = aux_valid && aux_ready && (aux_waddr != '0);
        pop        = !rst && head_valid && (in_force || !pipe_we);
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Write-port mux; everything is held at zero while reset is asserted
    always_comb begin
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        stall_req = 1'b0;
        if (!rst) begin
            if (in_force) begin
                rf_we     = 1'b1;
                rf_waddr  = ent_addr_q[rd_ptr_q];
                rf_wdata  = ent_data_q[rd_ptr_q];
                stall_req = pipe_we;
            end else if (pipe_we) begin
                rf_we     = 1'b1;
                rf_waddr  = pipe_waddr;
                rf_wdata  = pipe_wdata;
            end else if (head_valid) begin
                rf_we     = 1'b1;
                rf_waddr  = ent_addr_q[rd_ptr_q];
                rf_wdata  = ent_data_q[rd_ptr_q];
            end
        end
    end

    // Pending-destination mask from the registered FIFO contents only
    always_comb begin
        aux_pend_mask = '0;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if ((count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(k)))) begin
                    aux_pend_mask[ent_addr_q[k]] = 1'b1;
                end
            end
        end
    end

    // FIFO storage; contents need no reset because count_q qualifies every entry
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= aux_waddr;
            ent_data_q[wr_ptr_q] <= aux_wdata;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // Starvation FSM: count cycles the head loses to the pipeline, force one grant at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_NORMAL;
            starve_cnt_q <= 4'd0;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    if (head_valid && pipe_we) begin
                        if (starve_cnt_q == WAIT_LAST) begin
                            state_q <= ST_FORCE;
                        end
                        if (starve_cnt_q < WAIT_MAX) begin
                            starve_cnt_q <= starve_cnt_q + 4'd1;
                        end
                    end else begin
                        starve_cnt_q <= 4'd0;
                    end
                end
                default: begin
                    state_q      <= ST_NORMAL;
                    starve_cnt_q <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized self-checking bench for rf_wb_arbiter against a queue model
module tb_rf_wb_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        stall_req;
    logic        aux_valid;
    logic [4:0]  aux_waddr;
    logic [31:0] aux_wdata;
    logic        aux_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] aux_pend_mask;

    rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_we       (pipe_we),
        .pipe_waddr    (pipe_waddr),
        .pipe_wdata    (pipe_wdata),
        .stall_req     (stall_req),
        .aux_valid     (aux_valid),
        .aux_waddr     (aux_waddr),
        .aux_wdata     (aux_wdata),
        .aux_ready     (aux_ready),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .aux_pend_mask (aux_pend_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    int          m_blocked;
    bit          m_force;
    bit          hold;
    logic [4:0]  held_a;
    logic [31:0] held_d;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                        input logic av, input logic [4:0] awa, input logic [31:0] awd);
        logic        e_we, e_stall, e_ready, grant_aux;
        logic [4:0]  e_a;
        logic [31:0] e_d, e_mask;
        if (hold && !r) begin
            pwe = 1'b1;
            pwa = held_a;
            pwd = held_d;
        end
        rst = r; pipe_we = pwe; pipe_waddr = pwa; pipe_wdata = pwd;
        aux_valid = av; aux_waddr = awa; aux_wdata = awd;

        e_we = 0; e_a = 0; e_d = 0; e_stall = 0; e_ready = 0; e_mask = 0; grant_aux = 0;
        if (!r) begin
            e_ready = (mq.size() < 2);
            foreach (mq[i]) e_mask[mq[i].a] = 1'b1;
            if (m_force || (!pwe && mq.size() > 0)) begin
                grant_aux = 1;
                e_we = 1; e_a = mq[0].a; e_d = mq[0].d;
                e_stall = m_force && pwe;
            end else if (pwe) begin
                e_we = 1; e_a = pwa; e_d = pwd;
            end
        end

        @(negedge clk);
        check_val("rf_we", 64'(rf_we), 64'(e_we));
        check_val("rf_waddr", 64'(rf_waddr), 64'(e_a));
        check_val("rf_wdata", 64'(rf_wdata), 64'(e_d));
        check_val("stall_req", 64'(stall_req), 64'(e_stall));
        check_val("aux_ready", 64'(aux_ready), 64'(e_ready));
        check_val("aux_pend_mask", 64'(aux_pend_mask), 64'(e_mask));

        if (r) begin
            mq.delete();
            m_blocked = 0;
            m_force = 0;
        end else begin
            if (m_force) begin
                m_force = 0;
                m_blocked = 0;
            end else if (mq.size() > 0 && pwe) begin
                m_blocked++;
                if (m_blocked >= MAX_WAIT) m_force = 1;
            end else begin
                m_blocked = 0;
            end
            if (grant_aux) void'(mq.pop_front());
            if (av && e_ready && awa != 5'd0) mq.push_back('{a: awa, d: awd});
        end
        hold = e_stall;
        held_a = pwa;
        held_d = pwd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dens;
        rst = 1; pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
        aux_valid = 0; aux_waddr = 0; aux_wdata = 0;
        m_blocked = 0; m_force = 0; hold = 0; held_a = 0; held_d = 0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 32'h9, 1, 4, 32'h7);

        // idle drain of a single entry
        step(0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // pipe priority and forced grant
        step(0, 1, 1, 32'h100, 1, 7, 32'hA5);
        for (int i = 2; i <= 9; i++) step(0, 1, 5'(i), 32'h100 + 32'(i), 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // full FIFO with a blocked third request held valid
        step(0, 1, 1, 32'h201, 1, 2, 32'h22);
        step(0, 1, 2, 32'h202, 1, 3, 32'h33);
        for (int i = 3; i < 16; i++) step(0, 1, 5'(i), 32'h200 + 32'(i), 1, 6, 32'h66);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);

        // r0 aux write is dropped
        step(0, 0, 0, 0, 1, 0, 32'h5);
        step(0, 0, 0, 0, 0, 0, 0);

        // back-to-back idle drain
        step(0, 1, 8, 32'h300, 1, 10, 32'h1);
        step(0, 1, 9, 32'h301, 1, 11, 32'h2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);

        // reset mid-drain discards buffered entries
        step(0, 1, 8, 32'h400, 1, 3, 32'h11);
        step(0, 1, 9, 32'h401, 1, 4, 32'h22);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);

        // randomized traffic with alternating pipeline density
        for (int i = 0; i < 3000; i++) begin
            dens = ((i / 200) % 2) ? 92 : 45;
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 99) < dens,
                 5'($urandom), $urandom,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                 $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
